// File: rtl/snd_voice_sched.sv
// snd_voice_sched: sample-rate scheduler for the 4-voice tone generator.
// Divides the system clock into a one-cycle sample_ena strobe. After each strobe, one
// shared note->frequency ROM is time-shared across the 4 voices, each ROM word is
// converted to a phase increment, and all 4 increments commit on the same cycle.
// Ports:
//   clock, reset_n        system clock, synchronous active-low reset
//   enable                run the sample divider (low holds it at 0)
//   note_we/voice/idx     note register write port
//   rom_addr / rom_data   shared combinational pitch ROM (address registered)
//   sample_ena            one-cycle strobe every CLK_DIV clocks
//   busy, update_done     scan in progress / one-cycle commit pulse
//   pinc0..pinc3          per-voice phase increments
module snd_voice_sched #(
    parameter int unsigned SAMPLE_RATE = 16384,
    parameter int unsigned CLK_DIV     = 1536,
    localparam int unsigned PW         = $clog2(SAMPLE_RATE)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          note_we,
    input  logic [1:0]    note_voice,
    input  logic [3:0]    note_idx,
    output logic [3:0]    rom_addr,
    input  logic [PW-1:0] rom_data,
    output logic          sample_ena,
    output logic          busy,
    output logic          update_done,
    output logic [PW-1:0] pinc0,
    output logic [PW-1:0] pinc1,
    output logic [PW-1:0] pinc2,
    output logic [PW-1:0] pinc3
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    // Modulus reduced to PW bits; a power-of-two rate becomes 0, giving 2^PW - rom_data.
    localparam logic [PW-1:0] SR_W = PW'(SAMPLE_RATE);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_COMMIT} state_e;

    state_e          state_q, state_d;
    logic [1:0]      v_q, v_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sample_ena_q, sample_ena_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      rom_addr_q, rom_addr_d;
    logic [3:0]      note_q  [4];
    logic [3:0]      note_d  [4];
    logic [3:0]      snap_q  [4];
    logic [3:0]      snap_d  [4];
    logic [PW-1:0]   stage_q [4];
    logic [PW-1:0]   stage_d [4];
    logic [PW-1:0]   pinc_q  [4];
    logic [PW-1:0]   pinc_d  [4];

    // State register; reset also abandons any scan in progress.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            v_q          <= '0;
            div_q        <= '0;
            sample_ena_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rom_addr_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                note_q[i]  <= '0;
                snap_q[i]  <= '0;
                stage_q[i] <= '0;
                pinc_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            div_q        <= div_d;
            sample_ena_q <= sample_ena_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rom_addr_q   <= rom_addr_d;
            note_q       <= note_d;
            snap_q       <= snap_d;
            stage_q      <= stage_d;
            pinc_q       <= pinc_d;
        end
    end

    // Divider, note registers, snapshot and scan FSM next-state.
    always_comb begin
        div_d        = '0;
        sample_ena_d = 1'b0;
        note_d       = note_q;
        snap_d       = snap_q;
        state_d      = state_q;
        v_d          = v_q;
        rom_addr_d   = rom_addr_q;
        stage_d      = stage_q;
        pinc_d       = pinc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (enable) begin
            if (div_q == DIV_LAST) begin
                sample_ena_d = 1'b1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        if (note_we) begin
            note_d[note_voice] = note_idx;
        end

        // Snapshot uses pre-edge notes, so a same-cycle write waits for the next sample.
        if (sample_ena_q) begin
            snap_d = note_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_ena_q) begin
                    state_d = ST_ADDR;
                    v_d     = 2'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_ADDR: begin
                rom_addr_d = snap_q[v_q];
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                stage_d[v_q] = SR_W - rom_data;
                if (v_q == 2'd3) begin
                    state_d = ST_COMMIT;
                end else begin
                    v_d     = v_q + 2'd1;
                    state_d = ST_ADDR;
                end
            end
            ST_COMMIT: begin
                pinc_d  = stage_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr    = rom_addr_q;
    assign sample_ena  = sample_ena_q;
    assign busy        = busy_q;
    assign update_done = done_q;
    assign pinc0       = pinc_q[0];
    assign pinc1       = pinc_q[1];
    assign pinc2       = pinc_q[2];
    assign pinc3       = pinc_q[3];

endmodule
